// File: rtl/data_memory_bank.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_bank
// Brief    : Single-port synchronous data memory with per-byte write enables,
//            registered read data, out-of-range detection and a post-reset
//            clearing sequencer. Optional macro MEM_BYPASS_EN selects
//            write-first forwarding for same-cycle read/write.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_bank #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 MemWrite,
    input  logic                 MemRead,
    input  logic [ADDR_W-1:0]    address,
    input  logic [WIDTH/8-1:0]   byte_en,
    input  logic [WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]     data_out,
    output logic                 read_valid,
    output logic                 busy,
    output logic                 addr_err
);

    localparam int                c_NBYTES = WIDTH / 8;
    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   c_DEPTH  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ONE    = ADDR_W'(1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0]    r_mem [DEPTH];

    logic                w_idle;
    logic                w_req;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_do_wr;
    logic                w_do_rd;
    logic [WIDTH-1:0]    w_old;
    logic [WIDTH-1:0]    w_merged;
    logic [WIDTH-1:0]    w_rd_word;

    assign w_idle     = (r_state == IDLE);
    assign w_req      = MemRead | MemWrite;
    assign w_in_range = ({1'b0, address} < c_DEPTH);
    assign w_idx      = w_in_range ? address : '0;
    assign w_do_wr    = w_idle & MemWrite & w_in_range;
    assign w_do_rd    = w_idle & MemRead;
    assign w_old      = r_mem[w_idx];

    for (genvar gi = 0; gi < c_NBYTES; gi++) begin : g_bytes
        assign w_merged[8*gi +: 8] = byte_en[gi] ? data_in[8*gi +: 8] : w_old[8*gi +: 8];
    end

`ifdef MEM_BYPASS_EN
    assign w_rd_word = MemWrite ? w_merged : w_old;
`else
    assign w_rd_word = w_old;
`endif

    // Clearing sequencer: one word per cycle, then hand over to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            CLEAR: begin
                if (r_ptr == c_LAST) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt   = r_ptr + c_ONE;
                end
            end
            IDLE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == CLEAR) begin
                r_mem[r_ptr] <= '0;
            end else if (w_do_wr) begin
                r_mem[w_idx] <= w_merged;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out   <= '0;
            read_valid <= 1'b0;
            addr_err   <= 1'b0;
            busy       <= 1'b1;
        end else begin
            read_valid <= w_do_rd;
            addr_err   <= w_idle & w_req & ~w_in_range;
            busy       <= (w_state_nxt == CLEAR);
            if (w_do_rd) begin
                data_out <= w_in_range ? w_rd_word : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_bank
// Brief    : Scoreboard bench for data_memory_bank (WIDTH=32, DEPTH=48).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_bank;

    logic        clock;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [5:0]  address;
    logic [3:0]  byte_en;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        read_valid;
    logic        busy;
    logic        addr_err;

    typedef struct packed {
        logic        rv;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef MEM_BYPASS_EN
    localparam logic [31:0] c_SIM = 32'h0102C0D0;
`else
    localparam logic [31:0] c_SIM = 32'h01020304;
`endif

    data_memory_bank #(.WIDTH(32), .DEPTH(48)) dut (
        .clock      (clock),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .address    (address),
        .byte_en    (byte_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .read_valid (read_valid),
        .busy       (busy),
        .addr_err   (addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Response monitor: every output pulse must match the oldest expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (read_valid || addr_err) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got rv=%0b err=%0b data=%h, required no pulse",
                         read_valid, addr_err, data_out);
            end else begin
                e = q.pop_front();
                if (read_valid !== e.rv || addr_err !== e.err || (e.rv && data_out !== e.data)) begin
                    n_fail++;
                    $display("FAIL resp: got rv=%0b err=%0b data=%h, required rv=%0b err=%0b data=%h",
                             read_valid, addr_err, data_out, e.rv, e.err, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic req(input logic we, input logic re, input logic [5:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic push, input exp_t e);
        MemWrite = we;
        MemRead  = re;
        address  = a;
        byte_en  = be;
        data_in  = d;
        if (push) q.push_back(e);
        @(negedge clock);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
        req(1'b1, 1'b0, a, be, d, (a >= 6'd48), exp_t'{1'b0, 32'h0, 1'b1});
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp);
        req(1'b0, 1'b1, a, 4'h0, 32'h0, 1'b1, exp_t'{1'b1, exp, (a >= 6'd48)});
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clock);
        end
    endtask

    initial begin : stim
        int n;
        reset    = 1'b1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        address  = '0;
        byte_en  = '0;
        data_in  = '0;
        repeat (2) @(negedge clock);
        chk("reset_busy", {31'b0, busy}, 32'h1);
        chk("reset_read_valid", {31'b0, read_valid}, 32'h0);
        chk("reset_addr_err", {31'b0, addr_err}, 32'h0);
        chk("reset_data_out", data_out, 32'h0);
        reset = 1'b0;
        wait_clear(n);
        chk("busy_len_initial", n, 32'd48);

        // Preload, then a reset must wipe it.
        wr(6'd5, 4'hF, 32'hDEADBEEF);
        rd(6'd5, 32'hDEADBEEF);
        pulse_reset();
        chk("reset_clears_data_out", data_out, 32'h0);
        wait_clear(n);
        chk("busy_len_after_pulse", n, 32'd48);
        rd(6'd5, 32'h0);

        // Requests during CLEAR must be ignored (mem[2] pre-set nonzero).
        wr(6'd2, 4'hF, 32'h12345678);
        pulse_reset();
        n = 0;
        while (busy && n < 200) begin
            MemWrite = (n >= 10 && n < 13);
            MemRead  = (n >= 10 && n < 16);
            address  = (n >= 13) ? 6'd60 : 6'd2;
            byte_en  = 4'hF;
            data_in  = 32'hAAAA5555;
            n++;
            @(negedge clock);
        end
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        chk("busy_len_gated", n, 32'd48);
        rd(6'd2, 32'h0);

        // Byte-lane merge.
        wr(6'd7, 4'hF, 32'h11223344);
        wr(6'd7, 4'b0101, 32'hAABBCCDD);
        rd(6'd7, 32'h11BB33DD);

        // Out-of-range write is dropped; back-to-back reads sweep memory.
        wr(6'd50, 4'hF, 32'hFFFFFFFF);
        for (int i = 0; i < 48; i++) begin
            rd(6'(i), (i == 7) ? 32'h11BB33DD : 32'h0);
        end
        rd(6'd7, 32'h11BB33DD);
        rd(6'd63, 32'h0);

        // Same-cycle read and partial write.
        wr(6'd3, 4'hF, 32'h01020304);
        req(1'b1, 1'b1, 6'd3, 4'b0011, 32'hA0B0C0D0, 1'b1, exp_t'{1'b1, c_SIM, 1'b0});
        rd(6'd3, 32'h0102C0D0);

        // Reset in the middle of a clear restarts the full sequence.
        pulse_reset();
        repeat (20) @(negedge clock);
        chk("busy_mid_clear", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        chk("busy_during_second_reset", {31'b0, busy}, 32'h1);
        reset = 1'b0;
        wait_clear(n);
        chk("busy_len_restart", n, 32'd48);
        rd(6'd7, 32'h0);
        rd(6'd3, 32'h0);

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
